// File: rtl/mole_pkg.sv
// -----------------------------------------------------------------------------
// mole_pkg
// Shared definitions for the mole spawner slice: FSM state encoding, default
// mole count, LFSR feedback mask, score width and the saturating score helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GAP      = 2'd1,
    LIT      = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam int DEFAULT_N_MOLES = 18;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  // Increment a score, holding at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == SCORE_MAX) begin
      r = v;
    end else begin
      r = v + SCORE_ONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// 16-bit right-shifting Galois LFSR. Advances on every clock edge; loads SEED
// while rst_n is low (synchronous).
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   q     out  current LFSR state
// -----------------------------------------------------------------------------
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = LFSR_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // State register: shift right, fold the mask in when a one falls out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (q[0]) begin
      q <= (q >> 1) ^ MASK;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// -----------------------------------------------------------------------------
// mole_spawner
// Round sequencer for the whack-a-mole game: waits a dark gap, lights one
// pseudo-random mole (never the same as the previous one), and darkens it on
// hit, miss or lit-timeout. Keeps saturating hit/miss scores.
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   tick          in   1-ms single-cycle strobe
//   enable        in   game running level
//   hit_pulse     in   detector hit, one cycle
//   miss_pulse    in   detector miss, one cycle
//   active_onehot out  lit mole lamp vector, one-hot or zero
//   mole_idx      out  index of current / last lit mole
//   hit_count     out  saturating hit score
//   miss_count    out  saturating miss score
//   busy          out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mole_spawner
  import mole_pkg::*;
#(
  parameter int          N_MOLES   = DEFAULT_N_MOLES,
  parameter int unsigned GAP_TICKS = 500,
  parameter int unsigned LIT_TICKS = 1200,
  parameter int unsigned ACK_TICKS = 50,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       enable,
  input  logic                       hit_pulse,
  input  logic                       miss_pulse,
  output logic [N_MOLES-1:0]         active_onehot,
  output logic [$clog2(N_MOLES)-1:0] mole_idx,
  output logic [SCORE_W-1:0]         hit_count,
  output logic [SCORE_W-1:0]         miss_count,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_MOLES);
  // One extra bit so LFSR slices up to 2*N_MOLES-1 compare cleanly against N.
  localparam logic [IDX_W:0] N_EXT  = N_MOLES[IDX_W:0];
  localparam logic [IDX_W:0] N_LAST = N_EXT - {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] C_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [N_MOLES-1:0] LAMP_LSB = {{(N_MOLES-1){1'b0}}, 1'b1};
  localparam logic [31:0] GAP_LAST = 32'(GAP_TICKS - 32'd1);
  localparam logic [31:0] LIT_LAST = 32'(LIT_TICKS - 32'd1);
  localparam logic [31:0] ACK_LAST = 32'(ACK_TICKS - 32'd1);

  state_t         state;
  logic [31:0]    tick_cnt;
  logic [15:0]    lfsr_q;
  logic [IDX_W:0] cand_raw;
  logic [IDX_W:0] cand_wrap;
  logic [IDX_W:0] cand;

  // Only the low IDX_W bits of the LFSR pick the mole.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_q[15:IDX_W];

  mole_lfsr #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Next-mole candidate: fold the LFSR slice into range, then step past the
  // previous mole so the same lamp never lights twice in a row.
  always_comb begin
    cand_raw = {1'b0, lfsr_q[IDX_W-1:0]};
    if (cand_raw >= N_EXT) begin
      cand_wrap = cand_raw - N_EXT;
    end else begin
      cand_wrap = cand_raw;
    end
    if (cand_wrap == {1'b0, mole_idx}) begin
      if (cand_wrap == N_LAST) begin
        cand = '0;
      end else begin
        cand = cand_wrap + C_ONE;
      end
    end else begin
      cand = cand_wrap;
    end
  end

  // Round FSM with registered lamp, index, scores and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= 32'd0;
      active_onehot <= '0;
      mole_idx      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      busy          <= 1'b0;
    end else if (!enable) begin
      // Scores and mole_idx hold so the display can still read them.
      state         <= IDLE;
      tick_cnt      <= 32'd0;
      active_onehot <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hit_count  <= '0;
          miss_count <= '0;
          tick_cnt   <= 32'd0;
          state      <= GAP;
          busy       <= 1'b1;
        end
        GAP: begin
          if (tick) begin
            if (tick_cnt == GAP_LAST) begin
              mole_idx      <= cand[IDX_W-1:0];
              active_onehot <= LAMP_LSB << cand;
              tick_cnt      <= 32'd0;
              state         <= LIT;
            end else begin
              tick_cnt <= tick_cnt + 32'd1;
            end
          end
        end
        LIT: begin
          // A pulse on the timeout tick is scored as that pulse.
          if (hit_pulse) begin
            hit_count     <= sat_inc(hit_count);
            active_onehot <= '0;
            tick_cnt      <= 32'd0;
            state         <= GAP;
          end else if (miss_pulse) begin
            miss_count    <= sat_inc(miss_count);
            active_onehot <= '0;
            tick_cnt      <= 32'd0;
            state         <= GAP;
          end else if (tick && (tick_cnt == LIT_LAST)) begin
            active_onehot <= '0;
            tick_cnt      <= 32'd0;
            state         <= WAIT_ACK;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        WAIT_ACK: begin
          // The detector should report the vanished mole as a miss; if it
          // stays silent for ACK_TICKS the miss is scored here instead.
          if (hit_pulse) begin
            hit_count <= sat_inc(hit_count);
            tick_cnt  <= 32'd0;
            state     <= GAP;
          end else if (miss_pulse) begin
            miss_count <= sat_inc(miss_count);
            tick_cnt   <= 32'd0;
            state      <= GAP;
          end else if (tick && (tick_cnt == ACK_LAST)) begin
            miss_count <= sat_inc(miss_count);
            tick_cnt   <= 32'd0;
            state      <= GAP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        default: begin
          state         <= IDLE;
          tick_cnt      <= 32'd0;
          active_onehot <= '0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// -----------------------------------------------------------------------------
// tb_mole_spawner
// Directed, table-driven bench for mole_spawner with GAP=3, LIT=5, ACK=4 ticks
// and a tick every fourth cycle. Mole choices are predicted by an independent
// LFSR model plus the documented selection rule.
// -----------------------------------------------------------------------------
module tb_mole_spawner;

  localparam int N   = 18;
  localparam int GAP = 3;
  localparam int LIT = 5;
  localparam int ACK = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk;
  logic         rst_n;
  logic         tick;
  logic         enable;
  logic         hit_pulse;
  logic         miss_pulse;
  logic [N-1:0] active_onehot;
  logic [4:0]   mole_idx;
  logic [7:0]   hit_count;
  logic [7:0]   miss_count;
  logic         busy;

  mole_spawner #(
    .N_MOLES   (N),
    .GAP_TICKS (GAP),
    .LIT_TICKS (LIT),
    .ACK_TICKS (ACK),
    .LFSR_SEED (SEED)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .enable        (enable),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .active_onehot (active_onehot),
    .mole_idx      (mole_idx),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value the DUT saw at the most recent edge.
  logic [15:0] m_lfsr = 16'h0000;
  logic [15:0] m_prev = 16'h0000;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (!rst_n) m_lfsr <= SEED;
    else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
    else m_lfsr <= m_lfsr >> 1;
  end

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_idx = 5'd0;
  bit was_lit = 1'b0;

  function automatic logic [4:0] pick(input logic [15:0] v, input logic [4:0] prev);
    int c;
    c = int'(v[4:0]);
    if (c >= N) c = c - N;
    if (c == int'(prev)) c = (c + 1) % N;
    return c[4:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock with the given strobes; checks every freshly lit mole.
  task automatic cyc(input bit t, input bit h, input bit m);
    logic [4:0] e;
    tick = t; hit_pulse = h; miss_pulse = m;
    @(posedge clk);
    #1;
    tick = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
    if (!rst_n) begin
      exp_idx = 5'd0;
    end else if (!was_lit && (active_onehot != '0)) begin
      e = pick(m_prev, exp_idx);
      chk("new_mole_idx", 32'(mole_idx), 32'(e));
      chk("no_repeat", 32'(e != exp_idx), 32'd1);
      chk("idx_range", 32'(mole_idx < 5'd18), 32'd1);
      exp_idx = e;
    end
    was_lit = (active_onehot != '0);
  endtask

  // Three quiet cycles then a tick cycle carrying the optional pulses.
  task automatic tick_period(input bit h, input bit m);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, h, m);
  endtask

  typedef struct {
    bit rst_n; bit en; int plain; int ticks;
    bit pulse; bit pt; bit hit; bit miss;
    bit exp_lit; bit exp_busy; int exp_hit; int exp_miss;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit e, input int p, input int t,
                     input bit pu, input bit pt, input bit h, input bit m,
                     input bit el, input bit eb, input int eh, input int em);
    vec_t v;
    v = '{r, e, p, t, pu, pt, h, m, el, eb, eh, em};
    vq.push_back(v);
  endtask

  initial begin
    int exp_hit;
    rst_n = 1'b0; enable = 1'b0; tick = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;

    //  rst en pl tk pu pt h  m  lit busy hit miss
    add(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset: all zero
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // enable -> busy next edge
    add(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0);  // gap, still dark
    add(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);  // lit on third tick
    add(1, 1, 0, 2, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0);  // hit 2 ticks into LIT
    add(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0);  // new mole
    add(1, 1, 0, 4, 0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);  // lit timeout -> WAIT_ACK
    add(1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1);  // detector miss
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 1, 1);  // no double count
    add(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 1, 1);  // timeout again
    add(1, 1, 0, 3, 0, 0, 0, 0, 0, 1, 1, 1);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2);  // self-scored miss
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 1, 2);
    add(1, 1, 0, 4, 0, 0, 0, 0, 1, 1, 1, 2);
    add(1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 2, 2);  // hit on timeout tick
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 2, 2);  // back via GAP
    add(1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 3, 2);  // hit beats miss
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 3, 2);
    add(1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 3, 3);  // miss with tick
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 3, 3);  // hit in GAP ignored
    add(1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 3, 3);  // miss in GAP ignored
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 3, 3);
    add(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 3, 3);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 4, 3);  // hit in WAIT_ACK
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 4, 3);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 3);  // disable while lit
    add(1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 4, 3);  // pulses in IDLE ignored
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // re-enable clears scores
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0);
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset while lit
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      enable = vq[i].en;
      repeat (vq[i].plain) cyc(1'b0, 1'b0, 1'b0);
      repeat (vq[i].ticks) tick_period(1'b0, 1'b0);
      if (vq[i].pulse) begin
        if (vq[i].pt) tick_period(vq[i].hit, vq[i].miss);
        else cyc(1'b0, vq[i].hit, vq[i].miss);
      end
      chk($sformatf("v%0d_lit", i), 32'(active_onehot != '0), 32'(vq[i].exp_lit));
      chk($sformatf("v%0d_lamp", i), 32'(active_onehot),
          vq[i].exp_lit ? (32'd1 << exp_idx) : 32'd0);
      chk($sformatf("v%0d_idx", i), 32'(mole_idx), 32'(exp_idx));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].exp_busy));
      chk($sformatf("v%0d_hits", i), 32'(hit_count), 32'(vq[i].exp_hit));
      chk($sformatf("v%0d_misses", i), 32'(miss_count), 32'(vq[i].exp_miss));
    end

    // Long run: 1000 hit rounds exercise saturation and the no-repeat rule.
    exp_hit = 0;
    for (int r = 0; r < 1000; r++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (exp_hit < 255) exp_hit++;
      chk("sat_dark", 32'(active_onehot), 32'd0);
      chk("sat_hits", 32'(hit_count), 32'(exp_hit));
      repeat (GAP) tick_period(1'b0, 1'b0);
      chk("sat_lamp", 32'(active_onehot), 32'd1 << exp_idx);
    end
    chk("sat_final", 32'(hit_count), 32'd255);
    chk("sat_misses", 32'(miss_count), 32'd0);

    // Disable at saturation: lamp off, scores and index held.
    enable = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("dis_lamp", 32'(active_onehot), 32'd0);
    chk("dis_hits", 32'(hit_count), 32'd255);
    chk("dis_idx", 32'(mole_idx), 32'(exp_idx));
    chk("dis_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Drives the `active_onehot` mole lamp vector consumed by the hit/miss detector. It closes the loop by consuming the detector's `hit_pulse` and `miss_pulse`.
- Each round it waits a gap, picks a pseudo-random mole (never the same one twice in a row), and lights it. The mole goes dark on hit, miss or lit-timeout.
- Keeps saturating hit/miss scores for the display path.

Parameters:
- N_MOLES, 18, number of moles/LEDs (2..32)
- GAP_TICKS, 500, dark interval between moles, in 1-ms ticks (>=1)
- LIT_TICKS, 1200, maximum time a mole stays lit, in ticks (>=1)
- ACK_TICKS, 50, after a lit-timeout, ticks to wait for the detector's miss before proceeding (>=1)
- LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  1-ms single-cycle strobe
- enable  in  1  game running level
- hit_pulse  in  1  from detector, 1 cycle
- miss_pulse  in  1  from detector, 1 cycle
- active_onehot  out  N_MOLES  lit mole, one-hot or zero
- mole_idx  out  $clog2(N_MOLES)  index of current/last lit mole
- hit_count  out  8  saturating hit score
- miss_count  out  8  saturating miss score
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Single clock `clk`; reset is synchronous and active-low (`rst_n`), sampled only on the rising edge.
  - On reset: state=IDLE, `active_onehot`=0, `mole_idx`=0, `hit_count`=0, `miss_count`=0, tick counter=0, LFSR=LFSR_SEED.
  - `rst_n` low mid-round darkens the mole on the next edge.
- LFSR:
  - 16-bit Galois LFSR, mask 16'hB400, advances every clk cycle regardless of state.
- States:
  - IDLE: counters hold. When `enable`=1, clear `hit_count` and `miss_count`, zero the tick counter, go to GAP.
  - GAP: count ticks. On the tick where the count reaches GAP_TICKS:
    - Compute the candidate index `c` = LFSR[k-1:0], k=$clog2(N_MOLES). If c>=N_MOLES, c=c-N_MOLES. Then if c equals `mole_idx`, c=(c+1) mod N_MOLES.
    - Register `mole_idx`=c and `active_onehot`=1<<c; go to LIT. The lamp is visible the cycle after the GAP exit edge.
  - LIT: count ticks from 0.
    - `hit_pulse` → `hit_count`++ (saturate at 255), `active_onehot`=0, go to GAP.
    - else `miss_pulse` → `miss_count`++ (saturate at 255), `active_onehot`=0, go to GAP.
    - else tick count reaches LIT_TICKS → `active_onehot`=0, go to WAIT_ACK.
  - WAIT_ACK (the detector reports the disappearance as a miss):
    - `miss_pulse` → `miss_count`++, go to GAP.
    - `hit_pulse` → `hit_count`++, go to GAP.
    - ACK_TICKS ticks with no pulse → `miss_count`++, go to GAP. The spawner scores the miss itself.
- Tick counter: zeroed on every state change.
- Priorities and boundaries:
  - `hit_pulse` beats `miss_pulse` and timeout in the same cycle.
  - A pulse on the same cycle as the LIT timeout tick counts as hit/miss, not timeout.
  - `hit_pulse`/`miss_pulse` in IDLE or GAP are ignored.
  - Saturation holds at 8'hFF; no wrap.
- `enable` deasserted in any state: next edge state=IDLE, `active_onehot`=0. Scores and `mole_idx` hold and stay readable until the next enable.
- One-hot invariant: `active_onehot` is 0 or has exactly one bit set, and that bit always equals `mole_idx` when non-zero.

Decomposition:
- Shared package `mole_pkg`:
  - state enum {IDLE, GAP, LIT, WAIT_ACK}
  - default N_MOLES constant
  - LFSR_MASK = 16'hB400
  - score width constant
- One sub-module `mole_lfsr`: 16-bit Galois LFSR with SEED and MASK parameters, ports clk/rst_n/q. The detector-side top instantiates `mole_spawner` alongside the detector.

Test Plan (GAP_TICKS=3, LIT_TICKS=5, ACK_TICKS=4, tick every 4 cycles):
- Reset/enable: hold `rst_n`=0 5 cycles, then `enable`=1 → all outputs 0 during reset; `busy`=1 next edge; `active_onehot` one-hot exactly 3 ticks later, bit == `mole_idx`.
- Hit path: pulse `hit_pulse` 2 ticks into LIT → next edge `active_onehot`=0 and `hit_count`=1; new mole after 3 ticks with a different `mole_idx`.
- Timeout path: no pulses → dark after 5 ticks; then `miss_pulse` → `miss_count`=1, no double count. Repeat with no `miss_pulse` → `miss_count` increments after 4 ticks.
- Simultaneous: `hit_pulse` on the LIT timeout tick → `hit_count`+1, `miss_count` unchanged, state goes to GAP, not WAIT_ACK.
- Saturation and no-repeat: force 300 hits → `hit_count`=255. Check over 1000 rounds that consecutive `mole_idx` values never match and all stay < 18.
- Disable/reset mid-round: `enable`=0 while lit → lamp 0 next edge, scores hold. `rst_n`=0 while lit → all outputs 0 next edge; re-enable clears scores.
